// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART constants and the TX arbiter state encoding   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_WIDTH_DATA = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick, search from ptr+1 upward   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int NB_REQ = 4,
    parameter int PW     = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] i_req,
    input  logic [PW-1:0]     i_ptr,
    output logic [NB_REQ-1:0] o_grant
);

    logic [NB_REQ-1:0] w_hi;
    logic [NB_REQ-1:0] w_lo;

    // Scanning downward leaves the lowest match; w_hi only considers indices above ptr.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                if (k > int'(i_ptr)) begin
                    w_hi    = '0;
                    w_hi[k] = 1'b1;
                end
                w_lo    = '0;
                w_lo[k] = 1'b1;
            end
        end
        o_grant = (w_hi != '0) ? w_hi : w_lo;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arb : round-robin byte arbiter feeding one UART transmitter  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = UART_WIDTH_DATA,
    parameter int NB_REQ     = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic [NB_REQ-1:0]            i_req,
    input  logic [NB_REQ-1:0]            i_last,
    input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
    output logic [NB_REQ-1:0]            o_ack,
    output logic [NB_REQ-1:0]            o_gnt,
    output logic                         o_we,
    output logic [WIDTH_DATA-1:0]        o_data,
    input  logic                         i_mty,
    output logic                         o_busy
);

    localparam int PW = $clog2(NB_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t             state_q;
    logic [NB_REQ-1:0]      gnt_q;
    logic [NB_REQ-1:0]      ack_q;
    logic                   we_q;
    logic [WIDTH_DATA-1:0]  data_q;
    logic [BW-1:0]          burst_q;
    logic                   last_q;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          own_q;

    logic [NB_REQ-1:0]      w_pick;
    logic [PW-1:0]          w_pick_idx;
    logic                   w_own_req;
    logic                   w_own_last;
    logic [WIDTH_DATA-1:0]  w_own_data;

    rr_pick #(
        .NB_REQ (NB_REQ),
        .PW     (PW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_grant (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = PW'(k);
            end
        end
    end

    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (own_q == PW'(k)) begin
                w_own_req  = i_req[k];
                w_own_last = i_last[k];
                w_own_data = i_data[k*WIDTH_DATA +: WIDTH_DATA];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            ptr_q   <= PW'(NB_REQ - 1);
            own_q   <= '0;
        end else begin
            // Write strobe and ack are single-cycle pulses unless LOAD fires below.
            we_q  <= 1'b0;
            ack_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        gnt_q   <= w_pick;
                        own_q   <= w_pick_idx;
                        burst_q <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_own_req) begin
                        ptr_q   <= own_q;
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (i_mty) begin
                        we_q    <= 1'b1;
                        data_q  <= w_own_data;
                        ack_q   <= gnt_q;
                        last_q  <= w_own_last;
                        burst_q <= burst_q + BW'(1);
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mty) begin
                        if (last_q || (burst_q == BW'(MAX_BURST))) begin
                            ptr_q   <= own_q;
                            gnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack  = ack_q;
    assign o_gnt  = gnt_q;
    assign o_we   = we_q;
    assign o_data = data_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arb : directed self-checking bench for uart_tx_arb        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_tx_arb;

    localparam int NB = 4;
    localparam int WD = 8;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic [NB-1:0]    req;
    logic [NB-1:0]    last;
    logic [NB*WD-1:0] data;
    logic             mty;
    logic [NB-1:0]    ack;
    logic [NB-1:0]    gnt;
    logic             we;
    logic [WD-1:0]    odata;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int nw     = 0;
    int       wr_who [0:255];
    logic [7:0] wr_dat [0:255];
    logic     prev_we = 1'b0;

    uart_tx_arb #(
        .WIDTH_DATA (WD),
        .NB_REQ     (NB),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .i_req  (req),
        .i_last (last),
        .i_data (data),
        .o_ack  (ack),
        .o_gnt  (gnt),
        .o_we   (we),
        .o_data (odata),
        .i_mty  (mty),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    // Protocol watch plus a log of every byte written to the transmitter.
    always @(negedge clk) begin
        int who;
        if (nrst) begin
            checks++;
            if (we && prev_we) begin
                errors++;
                $display("FAIL we_consecutive: o_we high two cycles in a row at %0t", $time);
            end
            checks++;
            if (ack !== (we ? gnt : '0)) begin
                errors++;
                $display("FAIL ack_vs_gnt: o_ack=%b o_we=%b o_gnt=%b at %0t", ack, we, gnt, $time);
            end
            if (we && nw < 256) begin
                who = -1;
                for (int k = 0; k < NB; k++) if (ack[k]) who = k;
                wr_who[nw] = who;
                wr_dat[nw] = odata;
                nw++;
            end
        end
        prev_we = we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        req  = '0;
        last = '0;
        data = '0;
        mty  = 1'b1;
        repeat (2) tick();
        nrst = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_idle_timeout: o_busy still %b after %0d cycles", name, busy, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, ack, we, odata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b ack=%b we=%b data=%h busy=%b, required all 0",
                     gnt, ack, we, odata, busy);
        end
    endtask

    task automatic test_single();
        int nw0;
        nw0  = nw;
        req  = 4'b0001;
        last = 4'b0001;
        data = {24'h0, 8'hA5};
        mty  = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || we !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt_n1: gnt=%b we=%b, required gnt=0001 we=0", gnt, we);
        end
        tick();
        checks++;
        if (we !== 1'b1 || ack !== 4'b0001 || odata !== 8'hA5) begin
            errors++;
            $display("FAIL single_write_n2: we=%b ack=%b data=%h, required 1 0001 a5", we, ack, odata);
        end
        req = '0;
        tick();
        checks++;
        if (we !== 1'b0 || odata !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: we=%b data=%h busy=%b, required 0 a5 1", we, odata, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle: busy=%b gnt=%b, required 0 0000", busy, gnt);
        end
        checks++;
        if (nw - nw0 !== 1) begin
            errors++;
            $display("FAIL single_count: %0d writes, required 1", nw - nw0);
        end
    endtask

    task automatic test_contention();
        int nw0;
        do_reset();
        nw0  = nw;
        req  = 4'b1111;
        last = 4'b0000;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        mty  = 1'b1;
        for (int c = 0; c < 300 && (nw - nw0) < 20; c++) tick();
        req = '0;
        wait_idle("contention");
        checks++;
        if (nw - nw0 !== 20) begin
            errors++;
            $display("FAIL contention_count: %0d writes, required 20", nw - nw0);
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (wr_who[nw0+i] !== (i / 4) % 4 || wr_dat[nw0+i] !== 8'h10 + 8'((i / 4) % 4)) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: requester %0d data %h, required %0d %h",
                             i, wr_who[nw0+i], wr_dat[nw0+i], (i / 4) % 4, 8'h10 + 8'((i / 4) % 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        seen = 1'b0;
        mty  = 1'b0;
        req  = 4'b0010;
        last = 4'b0010;
        data = {16'h0, 8'h3C, 8'h0};
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_gnt: gnt=%b, required 0010", gnt);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            seen = seen | we;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: o_we seen=%b while i_mty low, required 0", seen);
        end
        mty = 1'b1;
        tick();
        checks++;
        if (we !== 1'b1 || ack !== 4'b0010 || odata !== 8'h3C) begin
            errors++;
            $display("FAIL bp_release: we=%b ack=%b data=%h, required 1 0010 3c", we, ack, odata);
        end
        req = '0;
        wait_idle("bp");
    endtask

    task automatic test_withdraw();
        int nw0;
        nw0  = nw;
        mty  = 1'b0;
        req  = 4'b1100;
        last = 4'b1000;
        data = {8'h77, 24'h0};
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL wd_gnt2: gnt=%b, required 0100", gnt);
        end
        tick();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL wd_drop: gnt=%b busy=%b we=%b, required 0000 0 0", gnt, busy, we);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wd_next: gnt=%b, required 1000", gnt);
        end
        mty = 1'b1;
        tick();
        checks++;
        if (we !== 1'b1 || ack !== 4'b1000 || odata !== 8'h77 || nw - nw0 !== 0) begin
            errors++;
            $display("FAIL wd_write3: we=%b ack=%b data=%h prior=%0d, required 1 1000 77 0",
                     we, ack, odata, nw - nw0);
        end
        req = '0;
        wait_idle("wd");
    endtask

    task automatic test_early_end();
        int nw0;
        int a1;
        nw0  = nw;
        a1   = 0;
        req  = 4'b0110;
        last = 4'b0000;
        data = {8'h0, 8'h62, 8'h51, 8'h0};
        mty  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (ack[1]) begin
                a1++;
                last = 4'b0010;
            end
            if (ack[2]) begin
                req = '0;
                break;
            end
        end
        req = '0;
        wait_idle("early");
        checks++;
        if (nw - nw0 !== 3) begin
            errors++;
            $display("FAIL early_count: %0d writes, required 3", nw - nw0);
        end else begin
            checks++;
            if (wr_who[nw0] !== 1 || wr_who[nw0+1] !== 1 || wr_who[nw0+2] !== 2 ||
                wr_dat[nw0+1] !== 8'h51 || wr_dat[nw0+2] !== 8'h62) begin
                errors++;
                $display("FAIL early_order: %0d %0d %0d data %h %h, required 1 1 2 51 62",
                         wr_who[nw0], wr_who[nw0+1], wr_who[nw0+2], wr_dat[nw0+1], wr_dat[nw0+2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        req  = 4'b0010;
        last = 4'b0000;
        data = {16'h0, 8'h99, 8'h0};
        mty  = 1'b1;
        while (!ack[1] && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!ack[1]) begin
            errors++;
            $display("FAIL rm_ack_timeout: no ack after %0d cycles", n);
        end
        mty = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL rm_wait: busy=%b we=%b, required 1 0", busy, we);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, we, odata, busy} !== '0) begin
            errors++;
            $display("FAIL rm_async: gnt=%b ack=%b we=%b data=%h busy=%b, required all 0",
                     gnt, ack, we, odata, busy);
        end
        req = 4'b1111;
        mty = 1'b1;
        repeat (2) begin
            tick();
            seen = seen | we | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rm_held: activity=%b during reset, required 0", seen);
        end
        nrst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rm_priority: gnt=%b after release, required 0001", gnt);
        end
        req = '0;
        wait_idle("rm");
    endtask

    initial begin
        nrst = 1'b0;
        req  = '0;
        last = '0;
        data = '0;
        mty  = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_withdraw();
        test_early_end();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA, default 8: byte width, equal to the UART data width.
REQ-002 The block SHALL have parameter NB_REQ, default 4: number of requesters, range 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum bytes per grant before forced rotation, range 1..15.
REQ-004 Port i_clk  input  1: the only clock; all state changes on its rising edge.
REQ-005 Port i_nrst  input  1: reset, asynchronous assert, active-low.
REQ-006 Port i_req  input  NB_REQ: per-requester byte-valid, held until o_ack or withdrawn.
REQ-007 Port i_last  input  NB_REQ: per-requester marker that the presented byte ends its burst.
REQ-008 Port i_data  input  NB_REQ*WIDTH_DATA: requester k's byte at bits [k*WIDTH_DATA +: WIDTH_DATA].
REQ-009 Port o_ack  output  NB_REQ: one-cycle pulse to the requester whose byte was written to the UART.
REQ-010 Port o_gnt  output  NB_REQ: one-hot current owner; all-zero when idle.
REQ-011 Port o_we  output  1: write strobe to the UART transmitter i_we.
REQ-012 Port o_data  output  WIDTH_DATA: byte to the UART transmitter i_data.
REQ-013 Port i_mty  input  1: UART transmitter o_mty; high means a new byte may be written.
REQ-014 Port o_busy  output  1: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, GAP and WAIT.
REQ-016 IDLE with any i_req high: choose the winner round-robin, searching from index ptr+1 upward with wrap to 0; register o_gnt as one-hot on the winner; clear the burst counter; go to LOAD.
REQ-017 LOAD with i_req[g] high and i_mty high: register o_we=1, o_data=i_data[g], o_ack[g]=1 for exactly one cycle; register the current i_last[g] into last_q; increment the burst counter; go to GAP.
REQ-018 LOAD with i_req[g] high and i_mty low: stay in LOAD; no output changes.
REQ-019 LOAD with i_req[g] low: set ptr=g; clear o_gnt; go to IDLE with no write.
REQ-020 GAP SHALL last exactly one cycle and ignore i_mty, then go to WAIT; this covers the transmitter's empty-flag update delay.
REQ-021 WAIT with i_mty low: stay in WAIT.
REQ-022 WAIT with i_mty high and either last_q=1 or burst counter = MAX_BURST: set ptr=g; clear o_gnt; go to IDLE.
REQ-023 WAIT with i_mty high otherwise: go to LOAD keeping the same grant.
REQ-024 Latency: i_req rising in IDLE at cycle n with i_mty high gives o_gnt at n+1 and o_we/o_ack at n+2.
REQ-025 o_we, o_data, o_ack and o_gnt SHALL all be registered outputs; o_we and o_ack SHALL never be high in two consecutive cycles.
REQ-026 o_ack SHALL be high only in the same cycle as o_we, and only on the bit set in o_gnt.
REQ-027 The burst counter SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never exceed MAX_BURST.
REQ-028 i_req changes on non-granted requesters SHALL have no effect outside IDLE.
REQ-029 o_data SHALL hold its last written value when o_we is low.

Reset
REQ-030 While i_nrst is low, the block SHALL force state=IDLE, o_gnt=0, o_ack=0, o_we=0, o_data=0, o_busy=0, burst counter=0, last_q=0 and ptr=NB_REQ-1, so that requester 0 wins first.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately with no further write; the partially sent byte is the transmitter's concern.
REQ-032 The first grant SHALL be possible one cycle after i_nrst deasserts.

Structure
REQ-033 The shared package uart_pkg SHALL hold the FSM state encoding (2-bit) and the default WIDTH_DATA.
REQ-034 The round-robin search SHALL be one combinational sub-module, rr_pick, with inputs req and ptr and output one-hot grant; it contains no state.
REQ-035 uart_tx_arb SHALL connect directly to the tx instance inside uart, replacing the external i_we/i_data path.

Verification
REQ-036 Single requester: i_req=0001, i_last=1, i_data=8'hA5, i_mty high -> o_we and o_ack[0] at n+2, o_data=A5, then IDLE once i_mty returns high.
REQ-037 Contention: i_req=1111 all held, MAX_BURST=4, i_last=0 -> grants in order 0,1,2,3,0 with exactly 4 bytes each.
REQ-038 Backpressure: hold i_mty low 20 cycles in LOAD -> no o_we during those cycles; the byte is written on the first cycle after i_mty rises (registered).
REQ-039 Withdraw: requester 2 drops i_req in LOAD -> no o_we, ptr=2, next grant goes to requester 3 if it is requesting.
REQ-040 Early end: i_last=1 on the 2nd byte of requester 1 -> exactly 2 writes, then rotation to requester 2.
REQ-041 Reset mid-burst: pull i_nrst low during WAIT -> all outputs 0 asynchronously; after release, requester 0 has priority.
